// File: rtl/pipe_skid_reg_if.sv
// Stage-boundary bus for pipe_skid_reg: upstream handshake, downstream
// handshake, pipeline flush and the occupancy/state observation port.
interface pipe_skid_reg_if #(
  parameter int WIDTH = 32
);
  // Handshake: a beat transfers on a rising edge when valid & ready are both
  // high; the sender holds valid and data steady until that edge, and ready
  // may be used by the sender but never depends on valid combinationally.
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       level;

  modport slave (
    input  flush,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output level
  );

  modport master (
    output flush,
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  level
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Fully registered pipeline stage with a two-entry skid buffer: one beat per
// cycle under back-pressure, no combinational path across the boundary.
module pipe_skid_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  pipe_skid_reg_if.slave bus
);

  // The state value is the occupancy, so it doubles as the level output.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             out_valid_q;
  logic             in_ready_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  logic             in_fire;
  logic             out_fire;
  logic             load_main;
  logic             main_from_skid;
  logic             load_skid;

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (bus.flush) begin
      // Held entries are dropped, but the data registers keep their contents.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d   = BUSY;
            load_main = 1'b1;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d        = BUSY;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      main_q      <= RESET_VAL;
      skid_q      <= RESET_VAL;
    end else begin
      state_q     <= state_d;
      // Handshake flags come from the next state so they leave a flop.
      out_valid_q <= (state_d != EMPTY);
      in_ready_q  <= (state_d != FULL);
      if (load_main) begin
        main_q <= main_from_skid ? skid_q : bus.in_data;
      end
      if (load_skid) begin
        skid_q <= bus.in_data;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_data  = main_q;
  assign bus.level     = state_q;

  // A stalled output beat must not change underneath the consumer.
  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid_q && !bus.out_ready && !bus.flush) |=> $stable(main_q));

  a_level_legal: assert property (@(posedge clk) disable iff (rst)
    state_q != 2'd3);

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed table and corner sequences on a 32-bit
// instance, then randomized valid/ready traffic on an 8-bit instance.
module tb_pipe_skid_reg;

  logic clk = 1'b0;
  logic rst32;
  logic rst8;

  always #5 clk = ~clk;

  pipe_skid_reg_if #(.WIDTH(32)) if32 ();
  pipe_skid_reg_if #(.WIDTH(8))  if8 ();

  pipe_skid_reg #(.WIDTH(32), .RESET_VAL(32'hBFC0_0000)) dut32 (
    .clk (clk),
    .rst (rst32),
    .bus (if32)
  );

  pipe_skid_reg #(.WIDTH(8), .RESET_VAL(8'h5A)) dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (if8)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_data;
    logic        exp_out_valid;
    logic        exp_in_ready;
    logic [1:0]  exp_level;
    logic [31:0] exp_out_data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic r, input logic f, input logic iv,
                         input logic [31:0] d, input logic ordy);
    rst32          = r;
    if32.flush     = f;
    if32.in_valid  = iv;
    if32.in_data   = d;
    if32.out_ready = ordy;
  endtask

  task automatic check32(input string tag, input logic ov, input logic ir,
                         input logic [1:0] lvl, input logic [31:0] data);
    check({tag, ".out_valid"}, {31'b0, if32.out_valid}, {31'b0, ov});
    check({tag, ".in_ready"},  {31'b0, if32.in_ready},  {31'b0, ir});
    check({tag, ".level"},     {30'b0, if32.level},     {30'b0, lvl});
    check({tag, ".out_data"},  if32.out_data,           data);
  endtask

  task automatic add(input logic r, input logic f, input logic iv, input logic [31:0] d,
                     input logic ordy, input logic ov, input logic ir,
                     input logic [1:0] lvl, input logic [31:0] data);
    vec_t v;
    v.rst = r; v.flush = f; v.in_valid = iv; v.out_ready = ordy; v.in_data = d;
    v.exp_out_valid = ov; v.exp_in_ready = ir; v.exp_level = lvl; v.exp_out_data = data;
    vecs.push_back(v);
  endtask

  // Random-phase reference: the entries the stage currently holds, oldest first.
  logic [7:0] exp_q[$];
  logic [7:0] shown;

  initial begin
    drive32(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    rst8           = 1'b1;
    if8.flush      = 1'b0;
    if8.in_valid   = 1'b0;
    if8.in_data    = 8'h0;
    if8.out_ready  = 1'b0;

    // reset/idle, streaming, back-pressure, flush FULL, rst in BUSY, flush BUSY
    add(1,0,0,32'h0,0, 0,1,0,32'hBFC0_0000);
    add(0,0,0,32'h0,0, 0,1,0,32'hBFC0_0000);
    add(0,0,1,32'h1,1, 1,1,1,32'h1);
    add(0,0,1,32'h2,1, 1,1,1,32'h2);
    add(0,0,1,32'h3,1, 1,1,1,32'h3);
    add(0,0,1,32'h4,1, 1,1,1,32'h4);
    add(0,0,0,32'h0,1, 0,1,0,32'h4);
    add(0,0,1,32'hA,0, 1,1,1,32'hA);
    add(0,0,1,32'hB,0, 1,0,2,32'hA);
    add(0,0,1,32'hC,0, 1,0,2,32'hA);
    add(0,0,1,32'hC,1, 1,1,1,32'hB);
    add(0,0,1,32'hC,1, 1,1,1,32'hC);
    add(0,0,0,32'h0,1, 0,1,0,32'hC);
    add(0,0,1,32'hA,0, 1,1,1,32'hA);
    add(0,0,1,32'hB,0, 1,0,2,32'hA);
    add(0,1,1,32'hD,0, 0,1,0,32'hA);
    add(0,0,0,32'h0,1, 0,1,0,32'hA);
    add(0,0,1,32'h5,0, 1,1,1,32'h5);
    add(1,0,1,32'h6,1, 0,1,0,32'hBFC0_0000);
    add(0,0,0,32'h0,0, 0,1,0,32'hBFC0_0000);
    add(0,0,1,32'h7,0, 1,1,1,32'h7);
    add(0,1,1,32'h8,1, 0,1,0,32'h7);
    add(0,0,1,32'h9,1, 1,1,1,32'h9);
    add(0,0,0,32'h0,1, 0,1,0,32'h9);

    tick();
    foreach (vecs[i]) begin
      drive32(vecs[i].rst, vecs[i].flush, vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
      tick();
      check32($sformatf("vec%0d", i), vecs[i].exp_out_valid, vecs[i].exp_in_ready,
              vecs[i].exp_level, vecs[i].exp_out_data);
    end

    // Stream, then drop out_ready: exactly one extra beat is absorbed.
    for (int k = 0; k < 3; k++) begin
      drive32(1'b0, 1'b0, 1'b1, 32'd20 + 32'(k), 1'b1);
      tick();
      check32($sformatf("skid_stream%0d", k), 1'b1, 1'b1, 2'd1, 32'd20 + 32'(k));
    end
    drive32(1'b0, 1'b0, 1'b1, 32'd23, 1'b0);
    tick();
    check32("skid_absorb", 1'b1, 1'b0, 2'd2, 32'd22);
    for (int k = 0; k < 4; k++) begin
      drive32(1'b0, 1'b0, 1'b1, 32'd24 + 32'(k), 1'b0);
      tick();
      check32($sformatf("skid_stall%0d", k), 1'b1, 1'b0, 2'd2, 32'd22);
    end
    drive32(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    tick();
    check32("skid_drain0", 1'b1, 1'b1, 2'd1, 32'd23);
    tick();
    check32("skid_drain1", 1'b0, 1'b1, 2'd0, 32'd23);

    // Randomized traffic on the 8-bit stage.
    rst8 = 1'b1;
    tick();
    rst8  = 1'b0;
    shown = 8'h5A;
    exp_q.delete();
    check("rand_reset.out_data", {24'b0, if8.out_data}, {24'b0, shown});
    begin
      int ready_pct = 70;
      int valid_pct = 70;
      for (int cyc = 0; cyc < 10000; cyc++) begin
        logic       r, f, iv, ordy, hold, m_in, m_out;
        logic [7:0] d, prev_data;
        if (cyc % 500 == 0) begin
          ready_pct = $urandom_range(10, 95);
          valid_pct = $urandom_range(10, 95);
        end
        r    = ($urandom_range(0, 511) == 0);
        f    = ($urandom_range(0, 63) == 0);
        iv   = ($urandom_range(0, 99) < valid_pct);
        ordy = ($urandom_range(0, 99) < ready_pct);
        d    = 8'($urandom);
        rst8 = r; if8.flush = f; if8.in_valid = iv; if8.in_data = d; if8.out_ready = ordy;

        hold      = (exp_q.size() != 0) && !ordy && !f && !r;
        prev_data = if8.out_data;
        m_in      = iv && (exp_q.size() < 2);
        m_out     = (exp_q.size() != 0) && ordy;
        if (r) begin
          exp_q.delete();
          shown = 8'h5A;
        end else if (f) begin
          exp_q.delete();
        end else begin
          if (m_out) void'(exp_q.pop_front());
          if (m_in) exp_q.push_back(d);
          if (exp_q.size() != 0) shown = exp_q[0];
        end

        tick();
        check("rand.level",     {30'b0, if8.level},     32'(exp_q.size()));
        check("rand.out_valid", {31'b0, if8.out_valid}, {31'b0, exp_q.size() != 0});
        check("rand.in_ready",  {31'b0, if8.in_ready},  {31'b0, exp_q.size() != 2});
        check("rand.out_data",  {24'b0, if8.out_data},  {24'b0, shown});
        if (hold) check("rand.stall_stable", {24'b0, if8.out_data}, {24'b0, prev_data});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
